// File: rtl/pc_rx_pkg.sv
// Shared types and header-field helpers for the PC_RX packet decoder.
// Defines the state encoding, header bit positions and command encodings.
package pc_rx_pkg;

  typedef enum logic [1:0] {
    sHEADER  = 2'd0,
    sPAYLOAD = 2'd1,
    sCHECK   = 2'd2,
    sDONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_LOOPBACK = 2'd0,
    CMD_DATA     = 2'd1,
    CMD_SLM_CFG  = 2'd2,
    CMD_RSVD     = 2'd3
  } cmd_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Header layout: [31:24] sync, [23:18] reserved, [17:16] command, [15:0] length
  localparam int HDR_SYNC_MSB = 31;
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_CMD_MSB  = 17;
  localparam int HDR_CMD_LSB  = 16;
  localparam int HDR_LEN_MSB  = 15;
  localparam int HDR_LEN_LSB  = 0;

  function automatic logic [7:0] hdr_sync(input logic [31:0] w);
    return w[HDR_SYNC_MSB:HDR_SYNC_LSB];
  endfunction

  function automatic logic [1:0] hdr_cmd(input logic [31:0] w);
    return w[HDR_CMD_MSB:HDR_CMD_LSB];
  endfunction

  function automatic logic [15:0] hdr_len(input logic [31:0] w);
    return w[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/pc_rx_timeout_counter.sv
// Counts consecutive enabled cycles and pulses tc_o on the cycle the count
// would reach TIMEOUT_CYCLES; clear has priority and the count restarts after tc.
module pc_rx_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_rx_packet_decoder.sv
// Parses sync/command/length headers and payload words from a show-ahead RX FIFO.
// Optional trailing XOR checksum word is compiled in with PC_RX_PKT_CHECKSUM_EN.
module pc_rx_packet_decoder
  import pc_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_rx_fifo_output_word,
  input  logic        i_rx_fifo_is_empty_sig,
  output logic        o_rx_fifo_next_word_cmd,
  output logic [31:0] o_payload_word,
  output logic        o_payload_valid,
  output logic [1:0]  o_packet_command,
  output logic [15:0] o_packet_num_words,
  output logic        o_packet_fully_decoded,
  output logic        o_packet_error,
  output logic        o_busy
);

`ifdef PC_RX_PKT_CHECKSUM_EN
  localparam state_e STATE_AFTER_BODY = sCHECK;
`else
  localparam state_e STATE_AFTER_BODY = sDONE;
`endif

  state_e      state_q;
  logic        pop_q;
  logic        payload_valid_q;
  logic        fully_decoded_q;
  logic        error_q;
  logic [31:0] payload_word_q;
  logic [1:0]  command_q;
  logic [15:0] num_words_q;
  logic [15:0] words_left_q;

  logic        sample;
  logic        in_body;
  logic        tmo_en;
  logic        tmo_clr;
  logic        tmo_hit;
  logic [7:0]  hdr_sync_w;
  logic [1:0]  hdr_cmd_w;
  logic [15:0] hdr_len_w;
  logic        sync_ok;
  logic        len_ok;

  // FIFO handshake: the head word is taken when !empty && !pop_q; pop_q is the
  // acknowledge one cycle later, and that cycle is a gap while the head advances.
  assign sample  = !i_rx_fifo_is_empty_sig && !pop_q && (state_q != sDONE);
  assign in_body = (state_q == sPAYLOAD) || (state_q == sCHECK);
  assign tmo_en  = in_body && i_rx_fifo_is_empty_sig;
  assign tmo_clr = !in_body || sample;

  assign hdr_sync_w = hdr_sync(i_rx_fifo_output_word);
  assign hdr_cmd_w  = hdr_cmd(i_rx_fifo_output_word);
  assign hdr_len_w  = hdr_len(i_rx_fifo_output_word);
  assign sync_ok    = (hdr_sync_w == SYNC_BYTE);
  assign len_ok     = (32'(hdr_len_w) <= MAX_WORDS);

`ifdef PC_RX_PKT_CHECKSUM_EN
  logic [31:0] csum_q;
  logic        csum_ok;
  assign csum_ok = (i_rx_fifo_output_word == csum_q);
`endif

  pc_rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (i_clock),
    .rst_ni(i_reset),
    .en_i  (tmo_en),
    .clr_i (tmo_clr),
    .tc_o  (tmo_hit)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q         <= sHEADER;
      pop_q           <= 1'b0;
      payload_valid_q <= 1'b0;
      fully_decoded_q <= 1'b0;
      error_q         <= 1'b0;
      payload_word_q  <= '0;
      command_q       <= '0;
      num_words_q     <= '0;
      words_left_q    <= '0;
`ifdef PC_RX_PKT_CHECKSUM_EN
      csum_q          <= '0;
`endif
    end else begin
      pop_q           <= sample;
      payload_valid_q <= 1'b0;
      fully_decoded_q <= 1'b0;
      error_q         <= 1'b0;

      case (state_q)
        sHEADER: begin
          if (sample) begin
            if (!sync_ok || !len_ok) begin
              error_q <= 1'b1;
            end else begin
              command_q    <= hdr_cmd_w;
              num_words_q  <= hdr_len_w;
              words_left_q <= hdr_len_w;
`ifdef PC_RX_PKT_CHECKSUM_EN
              csum_q       <= i_rx_fifo_output_word;
`endif
              state_q      <= (hdr_len_w == 16'd0) ? STATE_AFTER_BODY : sPAYLOAD;
            end
          end
        end

        sPAYLOAD: begin
          // A sample beats a simultaneous timeout; the counter is cleared by it.
          if (sample) begin
            payload_word_q  <= i_rx_fifo_output_word;
            payload_valid_q <= 1'b1;
            words_left_q    <= words_left_q - 16'd1;
`ifdef PC_RX_PKT_CHECKSUM_EN
            csum_q          <= csum_q ^ i_rx_fifo_output_word;
`endif
            if (words_left_q == 16'd1) begin
              state_q <= STATE_AFTER_BODY;
            end
          end else if (tmo_hit) begin
            error_q <= 1'b1;
            state_q <= sHEADER;
          end
        end

`ifdef PC_RX_PKT_CHECKSUM_EN
        sCHECK: begin
          if (sample) begin
            if (csum_ok) begin
              state_q <= sDONE;
            end else begin
              error_q <= 1'b1;
              state_q <= sHEADER;
            end
          end else if (tmo_hit) begin
            error_q <= 1'b1;
            state_q <= sHEADER;
          end
        end
`endif

        sDONE: begin
          fully_decoded_q <= 1'b1;
          state_q         <= sHEADER;
        end

        default: begin
          state_q <= sHEADER;
        end
      endcase
    end
  end

  assign o_rx_fifo_next_word_cmd = pop_q;
  assign o_payload_word          = payload_word_q;
  assign o_payload_valid         = payload_valid_q;
  assign o_packet_command        = command_q;
  assign o_packet_num_words      = num_words_q;
  assign o_packet_fully_decoded  = fully_decoded_q;
  assign o_packet_error          = error_q;
  assign o_busy                  = (state_q != sHEADER);

endmodule

// File: tb/tb_pc_rx_packet_decoder.sv
// Directed bench for pc_rx_packet_decoder with a show-ahead FIFO model.
// Adds trailing checksum words and a checksum scenario when PC_RX_PKT_CHECKSUM_EN is set.
module tb_pc_rx_packet_decoder;

  localparam int unsigned TMO   = 50000;
  localparam int          DEPTH = 4096;
`ifdef PC_RX_PKT_CHECKSUM_EN
  localparam int TRAILER = 1;
`else
  localparam int TRAILER = 0;
`endif

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_rx_fifo_output_word;
  logic        i_rx_fifo_is_empty_sig;
  logic        o_rx_fifo_next_word_cmd;
  logic [31:0] o_payload_word;
  logic        o_payload_valid;
  logic [1:0]  o_packet_command;
  logic [15:0] o_packet_num_words;
  logic        o_packet_fully_decoded;
  logic        o_packet_error;
  logic        o_busy;

  pc_rx_packet_decoder #(
    .SYNC_BYTE     (8'hA5),
    .MAX_WORDS     (1024),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock                (i_clock),
    .i_reset                (i_reset),
    .i_rx_fifo_output_word  (i_rx_fifo_output_word),
    .i_rx_fifo_is_empty_sig (i_rx_fifo_is_empty_sig),
    .o_rx_fifo_next_word_cmd(o_rx_fifo_next_word_cmd),
    .o_payload_word         (o_payload_word),
    .o_payload_valid        (o_payload_valid),
    .o_packet_command       (o_packet_command),
    .o_packet_num_words     (o_packet_num_words),
    .o_packet_fully_decoded (o_packet_fully_decoded),
    .o_packet_error         (o_packet_error),
    .o_busy                 (o_busy)
  );

  // ---------------- clock ----------------
  always #5 i_clock = ~i_clock;

  // ---------------- show-ahead FIFO model ----------------
  logic [31:0] fifo_mem [DEPTH];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  int          empty_pop_cnt = 0;
  int          cycle_cnt = 0;

  assign i_rx_fifo_is_empty_sig = (rd_ptr == wr_ptr);
  assign i_rx_fifo_output_word  = (rd_ptr == wr_ptr) ? 32'hDEAD_BEEF : fifo_mem[rd_ptr % DEPTH];

  always @(posedge i_clock) begin
    cycle_cnt <= cycle_cnt + 1;
    if (o_rx_fifo_next_word_cmd) begin
      if (rd_ptr != wr_ptr) begin
        rd_ptr  <= rd_ptr + 1;
        pop_cnt <= pop_cnt + 1;
      end else begin
        empty_pop_cnt <= empty_pop_cnt + 1;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [31:0] got_q[$];
  int          got_cyc_q[$];
  int          fd_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          err_cyc = 0;
  logic [1:0]  fd_cmd = '0;
  logic [15:0] fd_len = '0;

  always @(negedge i_clock) begin
    if (o_payload_valid) begin
      got_q.push_back(o_payload_word);
      got_cyc_q.push_back(cycle_cnt);
    end
    if (o_packet_fully_decoded) begin
      fd_cnt = fd_cnt + 1;
      fd_cmd = o_packet_command;
      fd_len = o_packet_num_words;
    end
    if (o_packet_error) begin
      err_cnt = err_cnt + 1;
      err_cyc = cycle_cnt;
    end
    if (o_packet_error && o_packet_fully_decoded) both_cnt = both_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc_model = '0;
  int          b_got, b_fd, b_err, b_pop;

  task automatic run_cycles(input int n);
    repeat (n) @(posedge i_clock);
    @(negedge i_clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_ptr % DEPTH] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_hdr(input logic [31:0] h);
    acc_model = h;
    push_word(h);
  endtask

  task automatic push_pl(input logic [31:0] w);
    acc_model = acc_model ^ w;
    push_word(w);
  endtask

  task automatic push_trailer();
`ifdef PC_RX_PKT_CHECKSUM_EN
    push_word(acc_model);
`endif
  endtask

  task automatic snap();
    b_got = got_q.size();
    b_fd  = fd_cnt;
    b_err = err_cnt;
    b_pop = pop_cnt;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_reset = 1'b0;
    run_cycles(3);
    checks++;
    if ({o_rx_fifo_next_word_cmd, o_payload_valid, o_packet_fully_decoded, o_packet_error, o_busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {o_rx_fifo_next_word_cmd, o_payload_valid, o_packet_fully_decoded, o_packet_error, o_busy});
    end
    checks++;
    if ({o_payload_word, o_packet_command, o_packet_num_words} !== 50'b0) begin
      errors++;
      $display("FAIL reset_data: got word=%h cmd=%0d len=%0d expected zeros",
               o_payload_word, o_packet_command, o_packet_num_words);
    end
    i_reset = 1'b1;
    snap();
    run_cycles(3);
    checks++;
    if (pop_cnt - b_pop !== 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got pops=%0d busy=%b expected 0 0", pop_cnt - b_pop, o_busy);
    end
  endtask

  task automatic test_good_packet();
    snap();
    push_hdr(32'hA501_0003);
    push_pl(32'h11);
    push_pl(32'h22);
    push_pl(32'h33);
    push_trailer();
    run_cycles(20);
    checks++;
    if (got_q.size() - b_got !== 3) begin
      errors++;
      $display("FAIL good_strobes: got %0d expected 3", got_q.size() - b_got);
    end else begin
      checks++;
      if (got_q[b_got] !== 32'h11 || got_q[b_got+1] !== 32'h22 || got_q[b_got+2] !== 32'h33) begin
        errors++;
        $display("FAIL good_words: got %h %h %h expected 11 22 33",
                 got_q[b_got], got_q[b_got+1], got_q[b_got+2]);
      end
      checks++;
      if (got_cyc_q[b_got+1] - got_cyc_q[b_got] !== 2 || got_cyc_q[b_got+2] - got_cyc_q[b_got+1] !== 2) begin
        errors++;
        $display("FAIL good_spacing: got %0d %0d expected 2 2",
                 got_cyc_q[b_got+1] - got_cyc_q[b_got], got_cyc_q[b_got+2] - got_cyc_q[b_got+1]);
      end
    end
    checks++;
    if (fd_cnt - b_fd !== 1 || err_cnt - b_err !== 0) begin
      errors++;
      $display("FAIL good_done: got fd=%0d err=%0d expected 1 0", fd_cnt - b_fd, err_cnt - b_err);
    end
    checks++;
    if (fd_cmd !== 2'd1 || fd_len !== 16'd3) begin
      errors++;
      $display("FAIL good_fields: got cmd=%0d len=%0d expected 1 3", fd_cmd, fd_len);
    end
    checks++;
    if (pop_cnt - b_pop !== 4 + TRAILER || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL good_pops: got pops=%0d busy=%b expected %0d 0", pop_cnt - b_pop, o_busy, 4 + TRAILER);
    end
  endtask

  task automatic test_oversize();
    snap();
    push_word(32'hA502_0401);
    run_cycles(10);
    checks++;
    if (err_cnt - b_err !== 1 || fd_cnt - b_fd !== 0 || got_q.size() - b_got !== 0) begin
      errors++;
      $display("FAIL oversize_err: got err=%0d fd=%0d strobes=%0d expected 1 0 0",
               err_cnt - b_err, fd_cnt - b_fd, got_q.size() - b_got);
    end
    checks++;
    if (pop_cnt - b_pop !== 1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL oversize_pop: got pops=%0d busy=%b expected 1 0", pop_cnt - b_pop, o_busy);
    end
    checks++;
    if (o_packet_command !== 2'd1 || o_packet_num_words !== 16'd3) begin
      errors++;
      $display("FAIL oversize_hold: got cmd=%0d len=%0d expected 1 3", o_packet_command, o_packet_num_words);
    end
  endtask

  task automatic test_bad_sync();
    snap();
    push_word(32'h5A00_0001);
    push_hdr(32'hA500_0000);
    push_trailer();
    run_cycles(15);
    checks++;
    if (err_cnt - b_err !== 1 || fd_cnt - b_fd !== 1) begin
      errors++;
      $display("FAIL badsync_pulses: got err=%0d fd=%0d expected 1 1", err_cnt - b_err, fd_cnt - b_fd);
    end
    checks++;
    if (fd_cmd !== 2'd0 || fd_len !== 16'd0 || got_q.size() - b_got !== 0) begin
      errors++;
      $display("FAIL badsync_fields: got cmd=%0d len=%0d strobes=%0d expected 0 0 0",
               fd_cmd, fd_len, got_q.size() - b_got);
    end
    checks++;
    if (pop_cnt - b_pop !== 2 + TRAILER) begin
      errors++;
      $display("FAIL badsync_pops: got %0d expected %0d", pop_cnt - b_pop, 2 + TRAILER);
    end
  endtask

  task automatic test_max_len();
    snap();
    push_hdr(32'hA503_0400);
    for (int i = 1; i <= 1024; i++) push_pl({16'hC0DE, 16'(i)});
    push_trailer();
    run_cycles(2100);
    checks++;
    if (got_q.size() - b_got !== 1024) begin
      errors++;
      $display("FAIL maxlen_strobes: got %0d expected 1024", got_q.size() - b_got);
    end else begin
      checks++;
      if (got_q[b_got] !== 32'hC0DE_0001 || got_q[b_got+1023] !== 32'hC0DE_0400) begin
        errors++;
        $display("FAIL maxlen_words: got %h %h expected c0de0001 c0de0400",
                 got_q[b_got], got_q[b_got+1023]);
      end
    end
    checks++;
    if (fd_cnt - b_fd !== 1 || err_cnt - b_err !== 0 || fd_cmd !== 2'd3 || fd_len !== 16'h0400) begin
      errors++;
      $display("FAIL maxlen_done: got fd=%0d err=%0d cmd=%0d len=%0d expected 1 0 3 1024",
               fd_cnt - b_fd, err_cnt - b_err, fd_cmd, fd_len);
    end
  endtask

  task automatic test_back_to_back();
    snap();
    push_hdr(32'hA501_0001);
    push_pl(32'h77);
    push_trailer();
    push_hdr(32'hA502_0002);
    push_pl(32'h88);
    push_pl(32'h99);
    push_trailer();
    run_cycles(30);
    checks++;
    if (fd_cnt - b_fd !== 2 || err_cnt - b_err !== 0) begin
      errors++;
      $display("FAIL b2b_done: got fd=%0d err=%0d expected 2 0", fd_cnt - b_fd, err_cnt - b_err);
    end
    checks++;
    if (got_q.size() - b_got !== 3) begin
      errors++;
      $display("FAIL b2b_strobes: got %0d expected 3", got_q.size() - b_got);
    end else begin
      checks++;
      if (got_q[b_got] !== 32'h77 || got_q[b_got+1] !== 32'h88 || got_q[b_got+2] !== 32'h99) begin
        errors++;
        $display("FAIL b2b_words: got %h %h %h expected 77 88 99",
                 got_q[b_got], got_q[b_got+1], got_q[b_got+2]);
      end
    end
    checks++;
    if (fd_cmd !== 2'd2 || fd_len !== 16'd2) begin
      errors++;
      $display("FAIL b2b_fields: got cmd=%0d len=%0d expected 2 2", fd_cmd, fd_len);
    end
  endtask

  task automatic test_timeout();
    snap();
    push_hdr(32'hA501_0002);
    push_pl(32'h0000_AAAA);
    run_cycles(TMO - 20);
    checks++;
    if (err_cnt - b_err !== 0 || o_busy !== 1'b1 || got_q.size() - b_got !== 1) begin
      errors++;
      $display("FAIL timeout_early: got err=%0d busy=%b strobes=%0d expected 0 1 1",
               err_cnt - b_err, o_busy, got_q.size() - b_got);
    end
    run_cycles(40);
    checks++;
    if (err_cnt - b_err !== 1 || fd_cnt - b_fd !== 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: got err=%0d fd=%0d busy=%b expected 1 0 0",
               err_cnt - b_err, fd_cnt - b_fd, o_busy);
    end else if (got_q.size() - b_got == 1) begin
      checks++;
      if (err_cyc - got_cyc_q[b_got] !== TMO + 1) begin
        errors++;
        $display("FAIL timeout_latency: got %0d expected %0d", err_cyc - got_cyc_q[b_got], TMO + 1);
      end
    end
    snap();
    push_hdr(32'hA501_0001);
    push_pl(32'h0000_1234);
    push_trailer();
    run_cycles(15);
    checks++;
    if (fd_cnt - b_fd !== 1 || err_cnt - b_err !== 0 || got_q.size() - b_got !== 1) begin
      errors++;
      $display("FAIL timeout_recover: got fd=%0d err=%0d strobes=%0d expected 1 0 1",
               fd_cnt - b_fd, err_cnt - b_err, got_q.size() - b_got);
    end else begin
      checks++;
      if (got_q[b_got] !== 32'h0000_1234) begin
        errors++;
        $display("FAIL timeout_recover_word: got %h expected 00001234", got_q[b_got]);
      end
    end
  endtask

  task automatic test_reset_mid();
    snap();
    push_hdr(32'hA501_0003);
    push_pl(32'h11);
    run_cycles(6);
    checks++;
    if (o_busy !== 1'b1 || got_q.size() - b_got !== 1) begin
      errors++;
      $display("FAIL rstmid_pre: got busy=%b strobes=%0d expected 1 1", o_busy, got_q.size() - b_got);
    end
    i_reset = 1'b0;
    #1;
    checks++;
    if ({o_rx_fifo_next_word_cmd, o_payload_valid, o_packet_fully_decoded, o_packet_error, o_busy} !== 5'b0 ||
        {o_payload_word, o_packet_command, o_packet_num_words} !== 50'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got busy=%b word=%h cmd=%0d len=%0d expected all zero",
               o_busy, o_payload_word, o_packet_command, o_packet_num_words);
    end
    wr_ptr = rd_ptr;
    run_cycles(3);
    i_reset = 1'b1;
    run_cycles(3);
    push_hdr(32'hA502_0001);
    push_pl(32'h55);
    push_trailer();
    run_cycles(15);
    checks++;
    if (err_cnt - b_err !== 0 || fd_cnt - b_fd !== 1 || fd_cmd !== 2'd2 || fd_len !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_after: got err=%0d fd=%0d cmd=%0d len=%0d expected 0 1 2 1",
               err_cnt - b_err, fd_cnt - b_fd, fd_cmd, fd_len);
    end
    checks++;
    if (got_q.size() - b_got !== 2 || got_q[got_q.size()-1] !== 32'h55) begin
      errors++;
      $display("FAIL rstmid_word: got strobes=%0d last=%h expected 2 00000055",
               got_q.size() - b_got, got_q[got_q.size()-1]);
    end
  endtask

`ifdef PC_RX_PKT_CHECKSUM_EN
  task automatic test_checksum();
    snap();
    push_word(32'hA501_0001);
    push_word(32'h0000_00FF);
    push_word(32'hA501_00FE);
    run_cycles(15);
    checks++;
    if (fd_cnt - b_fd !== 1 || err_cnt - b_err !== 0 || pop_cnt - b_pop !== 3) begin
      errors++;
      $display("FAIL csum_good: got fd=%0d err=%0d pops=%0d expected 1 0 3",
               fd_cnt - b_fd, err_cnt - b_err, pop_cnt - b_pop);
    end
    snap();
    push_word(32'hA501_0001);
    push_word(32'h0000_00FF);
    push_word(32'h0000_0000);
    run_cycles(15);
    checks++;
    if (fd_cnt - b_fd !== 0 || err_cnt - b_err !== 1 || pop_cnt - b_pop !== 3 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL csum_bad: got fd=%0d err=%0d pops=%0d busy=%b expected 0 1 3 0",
               fd_cnt - b_fd, err_cnt - b_err, pop_cnt - b_pop, o_busy);
    end
    snap();
    push_word(32'hA500_0000);
    push_word(32'hA500_0000);
    run_cycles(12);
    checks++;
    if (fd_cnt - b_fd !== 1 || err_cnt - b_err !== 0 || pop_cnt - b_pop !== 2) begin
      errors++;
      $display("FAIL csum_empty: got fd=%0d err=%0d pops=%0d expected 1 0 2",
               fd_cnt - b_fd, err_cnt - b_err, pop_cnt - b_pop);
    end
  endtask
`endif

  task automatic test_invariants();
    checks++;
    if (both_cnt !== 0 || empty_pop_cnt !== 0) begin
      errors++;
      $display("FAIL invariants: got err_and_done=%0d empty_pops=%0d expected 0 0", both_cnt, empty_pop_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_reset = 1'b0;
    test_reset();
    test_good_packet();
    test_oversize();
    test_bad_sync();
    test_max_len();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
`ifdef PC_RX_PKT_CHECKSUM_EN
    test_checksum();
`endif
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_rx_packet_decoder.md
Name: pc_rx_packet_decoder

Overview:
- Sits between the PC_RX word FIFO and the data router.
- Pops 32-bit words from a show-ahead RX FIFO and parses header + payload packets.
- Presents payload words with a valid strobe, then pulses fully-decoded together with the latched command and length.
- Aborts cleanly on bad sync, oversize length or mid-packet starvation.

Parameters:
- SYNC_BYTE, 8'hA5, required value of header bits [31:24].
- MAX_WORDS, 1024, largest accepted payload length; larger lengths are an error.
- TIMEOUT_CYCLES, 50000, consecutive empty-FIFO cycles tolerated mid-packet before abort.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_fifo_output_word  in  32  FIFO head word; valid whenever FIFO is not empty (show-ahead).
- i_rx_fifo_is_empty_sig  in  1  FIFO empty flag.
- o_rx_fifo_next_word_cmd  out  1  registered 1-cycle pop pulse.
- o_payload_word  out  32  current payload word.
- o_payload_valid  out  1  1-cycle strobe qualifying o_payload_word.
- o_packet_command  out  2  command of the last accepted header.
- o_packet_num_words  out  16  payload length of the last accepted header.
- o_packet_fully_decoded  out  1  1-cycle pulse at successful packet end.
- o_packet_error  out  1  1-cycle pulse on any abort.
- o_busy  out  1  high while in any state other than sHEADER.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state sHEADER; counters and timeout cleared. Reset mid-packet discards the partial packet with no error pulse.
- Header format:
  - [31:24] sync byte.
  - [23:18] reserved, ignored.
  - [17:16] command.
  - [15:0] N, the payload word count.
- Pop rule:
  - A word is sampled only when FIFO is not empty and no pop is pending.
  - Sampling sets o_rx_fifo_next_word_cmd=1 on the next edge; the following cycle is a mandatory gap, because the FIFO head updates.
  - Maximum throughput is one word per 2 cycles. Every sampled word is popped exactly once, including dropped ones.
- sHEADER:
  - Sync mismatch: pop the word, pulse o_packet_error, stay in sHEADER.
  - Sync ok and N > MAX_WORDS: pop, pulse o_packet_error, stay.
  - Sync ok and N == 0: pop, latch command/length, go to sDONE (or sCHECK when the optional feature is compiled in).
  - Otherwise: pop, latch command/length, load word counter with N, go to sPAYLOAD.
- sPAYLOAD:
  - Each sampled word drives o_payload_word with o_payload_valid=1 in the same cycle as the pop pulse.
  - The counter decrements on each word; on the last word go to sDONE/sCHECK.
  - o_payload_word holds its value between strobes.
- sDONE: o_packet_fully_decoded=1 for exactly one cycle, then sHEADER. o_packet_command and o_packet_num_words hold until the next accepted header.
- Timeout:
  - In sPAYLOAD/sCHECK, a counter increments each cycle the FIFO is empty and clears on any sample.
  - Reaching TIMEOUT_CYCLES: pulse o_packet_error, go to sHEADER. The fully-decoded pulse is never issued for that packet.
- Simultaneous events: a sample and the timeout reaching its limit in the same cycle → the sample wins and the counter clears.
- o_packet_error and o_packet_fully_decoded are never high together.

Optional Feature:
- Macro: PC_RX_PKT_CHECKSUM_EN.
- Defined:
  - State sCHECK follows the payload (including N == 0) and consumes one trailing word.
  - Expected value = XOR of the header and all payload words.
  - Match → sDONE. Mismatch → pop, pulse o_packet_error, go to sHEADER.
- Undefined: no sCHECK state and no trailing word; the XOR accumulator is not synthesised.

Decomposition:
- Shared package pc_rx_pkg holds:
  - state enum (sHEADER, sPAYLOAD, sCHECK, sDONE);
  - header field bit positions;
  - command encodings (CMD_LOOPBACK=0, CMD_DATA=1, CMD_SLM_CFG=2, CMD_RSVD=3);
  - SYNC_BYTE default.
- One sub-module, pc_rx_timeout_counter: enable, clear, terminal-count pulse, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Header 32'hA501_0003 + words 11,22,33 pre-loaded → three o_payload_valid strobes with 11,22,33, spaced 2 cycles apart; then o_packet_fully_decoded pulse with command=1, num_words=3; 4 pops total.
- Word 32'h5A00_0001 then a good header 32'hA500_0000 → one o_packet_error, then fully_decoded with command=0, num_words=0.
- Header 32'hA502_0401 (N=1025) → error pulse, header popped, no payload strobes.
- Header N=2, one payload word, FIFO then empty for 50000 cycles → o_packet_error; a later good packet decodes normally.
- i_reset low mid-payload (1 of 3 words delivered) → outputs 0 immediately, state sHEADER, no error pulse.
- With checksum enabled: header A501_0001, payload 0000_00FF, check word A501_00FE → fully_decoded; check word 0 → error.
